// File: rtl/motor_step_gen.sv
// motor_step_gen: turns the 14-bit motor command word into step/dir/enable
// signals for an external stepper driver. It enforces the minimum pulse width,
// the minimum low time and the direction setup time, and it keeps a signed
// step-position count.
module motor_step_gen #(
   parameter int unsigned PRESCALE  = 50,
   parameter int unsigned PULSE_W   = 100,
   parameter int unsigned DIR_SETUP = 50,
   parameter int unsigned POS_W     = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [13:0]      cmd,
   input  logic             clear_pos,
   output logic             step,
   output logic             dir,
   output logic             en_n,
   output logic             busy,
   output logic [POS_W-1:0] position
);

   // A 12-bit period times a 16-bit prescale fits in 28 bits. The elapsed
   // counter has one extra bit so that elapsed+1 can never wrap.
   localparam int unsigned PROD_W = 28;
   localparam int unsigned CNT_W  = PROD_W + 1;
   localparam int unsigned PH_W   = 16;

   localparam logic [PH_W-1:0]   PULSE_LAST = PH_W'(PULSE_W - 1);
   localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(DIR_SETUP - 1);
   localparam logic [PROD_W-1:0] PRESCALE_P = PROD_W'(PRESCALE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_HIGH  = 2'd2,
      S_LOW   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_nxt_state;

   logic                r_step;
   logic                r_dir;
   logic                r_en_n;
   logic                r_busy;
   logic [POS_W-1:0]    r_pos;
   logic [PROD_W-1:0]   r_target;
   logic [CNT_W-1:0]    r_elapsed;
   logic [PH_W-1:0]     r_phase;

   logic                w_nxt_step;
   logic                w_nxt_dir;
   logic                w_nxt_en_n;
   logic [PROD_W-1:0]   w_nxt_target;
   logic [CNT_W-1:0]    w_nxt_elapsed;
   logic [PH_W-1:0]     w_nxt_phase;
   logic                w_boundary;
   logic                w_rise;
   logic                w_cmd_run;
   logic [PROD_W-1:0]   w_cmd_target;
   logic                w_period_done;
   logic                w_low_done;

   // Decode the live command word for the boundary decision.
   assign w_cmd_run     = cmd[13] && (cmd[11:0] != 12'd0);
   assign w_cmd_target  = PROD_W'(cmd[11:0]) * PRESCALE_P;
   assign w_period_done = (r_elapsed + CNT_W'(1)) >= CNT_W'(r_target);
   assign w_low_done    = (r_phase >= PULSE_LAST);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Next-state logic and next values of the timing counters and driver pins.
   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_step    = r_step;
      w_nxt_dir     = r_dir;
      w_nxt_en_n    = r_en_n;
      w_nxt_target  = r_target;
      w_nxt_elapsed = r_elapsed;
      w_nxt_phase   = r_phase;
      w_boundary    = 1'b0;
      w_rise        = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_boundary = 1'b1;
         end

         S_SETUP: begin
            if (r_phase == SETUP_LAST) begin
               w_nxt_state   = S_HIGH;
               w_nxt_step    = 1'b1;
               w_rise        = 1'b1;
               w_nxt_phase   = '0;
               w_nxt_elapsed = '0;
            end else begin
               w_nxt_phase = r_phase + PH_W'(1);
            end
         end

         S_HIGH: begin
            w_nxt_elapsed = r_elapsed + CNT_W'(1);
            if (r_phase == PULSE_LAST) begin
               w_nxt_state = S_LOW;
               w_nxt_step  = 1'b0;
               w_nxt_phase = '0;
            end else begin
               w_nxt_phase = r_phase + PH_W'(1);
            end
         end

         S_LOW: begin
            if (w_period_done && w_low_done) begin
               w_boundary = 1'b1;
            end else begin
               w_nxt_elapsed = r_elapsed + CNT_W'(1);
               // The low-time count saturates once the minimum is met.
               if (!w_low_done) begin
                  w_nxt_phase = r_phase + PH_W'(1);
               end
            end
         end

         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_step  = 1'b0;
         end
      endcase

      // The boundary decision samples the live command. The period captured
      // here stays fixed for the whole step.
      if (w_boundary) begin
         w_nxt_en_n    = ~cmd[13];
         w_nxt_target  = w_cmd_target;
         w_nxt_elapsed = '0;
         w_nxt_phase   = '0;
         w_nxt_step    = 1'b0;
         if (!w_cmd_run) begin
            w_nxt_state = S_IDLE;
         end else if (cmd[12] != r_dir) begin
            w_nxt_dir   = cmd[12];
            w_nxt_state = S_SETUP;
         end else begin
            w_nxt_state = S_HIGH;
            w_nxt_step  = 1'b1;
            w_rise      = 1'b1;
         end
      end
   end

   // Registered driver outputs, timing counters and the busy flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_step    <= 1'b0;
         r_dir     <= 1'b0;
         r_en_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_target  <= '0;
         r_elapsed <= '0;
         r_phase   <= '0;
      end else begin
         r_step    <= w_nxt_step;
         r_dir     <= w_nxt_dir;
         r_en_n    <= w_nxt_en_n;
         r_busy    <= (w_nxt_state != S_IDLE);
         r_target  <= w_nxt_target;
         r_elapsed <= w_nxt_elapsed;
         r_phase   <= w_nxt_phase;
      end
   end

   // Position counter. It moves on each step rise; a clear on the same edge wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pos <= '0;
      end else if (clear_pos) begin
         r_pos <= '0;
      end else if (w_rise) begin
         if (w_nxt_dir) begin
            r_pos <= r_pos - POS_W'(1);
         end else begin
            r_pos <= r_pos + POS_W'(1);
         end
      end
   end

   assign step     = r_step;
   assign dir      = r_dir;
   assign en_n     = r_en_n;
   assign busy     = r_busy;
   assign position = r_pos;

endmodule
